d_cache: RTL
============

# d_cache

Direct-mapped, write-through, no-write-allocate data cache with 4-word (16-byte) lines. It sits directly downstream of the CPU's data-side SRAM-to-SRAM-like adapter and consumes that adapter's sram-like request stream. It issues single-word sram-like transactions toward the memory/AXI bridge for line refills, write-throughs and uncached accesses.

## Interface
- INDEX_WIDTH, 6: line index bits; 2^INDEX_WIDTH lines; tag = addr[31:INDEX_WIDTH+4]
- clk  in  1  clock; all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- cpu_data_req  in  1  request valid; held until cpu_data_addr_ok
- cpu_data_wr  in  1  1 = write
- cpu_data_size  in  2  0 = byte, 1 = half, 2 = word
- cpu_data_addr  in  32  byte address
- cpu_data_wdata  in  32  write data, byte lanes aligned to address
- cpu_data_rdata  out  32  read data; valid when cpu_data_data_ok
- cpu_data_addr_ok  out  1  request accepted this cycle
- cpu_data_data_ok  out  1  transaction complete, 1-cycle pulse
- mem_req, mem_wr  out  1 each  memory request and direction
- mem_size  out  2  memory access size
- mem_addr, mem_wdata  out  32 each  memory address and write data
- mem_rdata  in  32  memory read data
- mem_addr_ok, mem_data_ok  in  1 each  memory handshakes
- stat_hit, stat_miss  out  32 each  statistics counters (see Configuration)

## Operation
- States: IDLE, LOOKUP, REFILL, WRITE, UNCACHED, RESP.
- IDLE
  - cpu_data_addr_ok = cpu_data_req.
  - On acceptance, latch addr, wr, size and wdata, then go to LOOKUP.
  - No other state asserts addr_ok, so at most one CPU transaction is outstanding.
- LOOKUP
  - If addr[31:29] = 3'b101, go to UNCACHED.
  - hit = valid[index] and tag match.
  - Read hit: data_ok with the word selected by addr[3:2], then IDLE.
  - Read miss: go to REFILL.
  - Write, hit or miss: on a hit, merge the bytes into the line now; then go to WRITE.
- REFILL
  - Four sequential word reads at {tag, index, k, 2'b00}, k = 0..3, with mem_size = 2.
  - Each returned word is written into the line.
  - After the fourth mem_data_ok: set valid and tag, go to RESP.
- RESP: data_ok with the requested word, then IDLE.
- WRITE: one memory write with the latched addr, size and wdata. On mem_data_ok, assert data_ok and go to IDLE. A write miss does not allocate.
- UNCACHED: one memory access with the latched wr, addr, size and wdata, cache untouched. On mem_data_ok, assert data_ok (rdata = mem_rdata for reads) and go to IDLE.
- Byte merge lanes:
  - size 0: lane addr[1:0].
  - size 1: lanes {addr[1], 0} and {addr[1], 1}.
  - size 2: all four lanes.
- Memory handshake:
  - mem_req is held high until mem_addr_ok, then dropped.
  - The block then waits for mem_data_ok.
  - If mem_addr_ok and mem_data_ok arrive in the same cycle, both are taken and that access is complete.
  - Only one memory access is outstanding at a time.
- cpu_data_rdata is registered and holds its value until the next read's data_ok.

## Timing
- Reset (asynchronous):
  - State returns to IDLE; all valid bits clear.
  - cpu_data_addr_ok, cpu_data_data_ok, mem_req and mem_wr are 0; cpu_data_rdata, mem_addr, mem_wdata, mem_size, stat_hit and stat_miss are 0.
  - Tag and data arrays are not reset.
- Reset mid-REFILL: the line stays invalid; the in-flight memory response is ignored after reset.
- Read-hit latency: addr_ok in cycle T, data_ok in T+1.
- Read-miss latency: data_ok one cycle after the fourth mem_data_ok.
- Write and uncached accesses: data_ok in the same cycle as mem_data_ok.
- mem_req first rises in the cycle after entering REFILL, WRITE or UNCACHED.
  - It rises again the cycle after each refill mem_data_ok.
- Back-to-back: a new addr_ok is possible in the cycle after data_ok.

## Configuration
- D_CACHE_STAT_EN defined:
  - stat_hit increments on each cached LOOKUP hit (read or write).
  - stat_miss increments on each cached LOOKUP miss.
  - Both are 32-bit and wrap at 2^32.
- D_CACHE_STAT_EN undefined: stat_hit and stat_miss are constant 0 and no counter logic is generated.

## Test plan
- Read miss then hit:
  - Read 0x0000_0044; memory returns words 0x11, 0x22, 0x33, 0x44 for 0x40..0x4C.
  - Required: exactly 4 memory reads, then data_ok with rdata 0x22.
  - Re-read 0x48: data_ok at T+1 with rdata 0x33 and no mem_req.
- Byte write hit:
  - After the line above is filled, write size 0 to 0x41 with wdata 0x0000_AB00.
  - Required: one memory write with mem_size 0 and addr 0x41.
  - A subsequent read of 0x40 returns 0x0000_AB11.
- Write miss:
  - Write word 0xDEAD_BEEF to 0x1000 on a cold cache.
  - Required: one memory write; a following read of 0x1000 misses and refills.
- Uncached:
  - Read 0xBFAF_8000 twice.
  - Required: two single memory reads with mem_size 2; the cache is never filled.
- Handshake edges:
  - Memory asserts addr_ok and data_ok in the same cycle, and delays addr_ok by 3 cycles.
  - Required: no duplicate or lost requests; mem_req is held stable while waiting.
- Reset during REFILL:
  - Pull resetn low after 2 of 4 refill words.
  - Required: outputs go to zero immediately; a re-read of the same address refills all 4 words.

Source files
------------

// File: rtl/d_cache.sv
// ============================================================================
// Module   : d_cache
// Brief    : Direct-mapped, write-through, no-write-allocate data cache with
//            16-byte lines. Optional hit/miss counters under D_CACHE_STAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module d_cache #(
  parameter int INDEX_WIDTH = 6
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_data_req,
  input  logic        cpu_data_wr,
  input  logic [1:0]  cpu_data_size,
  input  logic [31:0] cpu_data_addr,
  input  logic [31:0] cpu_data_wdata,
  output logic [31:0] cpu_data_rdata,
  output logic        cpu_data_addr_ok,
  output logic        cpu_data_data_ok,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  output logic [31:0] stat_hit,
  output logic [31:0] stat_miss
);
  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int TAG_W = 28 - INDEX_WIDTH;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    REFILL   = 3'd2,
    WRITE    = 3'd3,
    UNCACHED = 3'd4,
    RESP     = 3'd5
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_addr, r_wdata, r_rdata;
  logic             r_wr, r_wait;
  logic [1:0]       r_size, r_cnt;
  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [31:0]      r_data [LINES*4];

  logic [INDEX_WIDTH-1:0] w_index;
  logic [TAG_W-1:0]       w_tag;
  logic                   w_uncached, w_hit, w_mem_state, w_issue;
  logic                   w_mem_accept, w_mem_done, w_rd_fire;
  logic [31:0]            w_word, w_rd_word, w_merged;
  logic [3:0]             w_be;

  assign w_index      = r_addr[INDEX_WIDTH+3:4];
  assign w_tag        = r_addr[31:INDEX_WIDTH+4];
  assign w_uncached   = (r_addr[31:29] == 3'b101);
  assign w_hit        = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_word       = r_data[{w_index, r_addr[3:2]}];
  assign w_mem_state  = (r_state == REFILL) || (r_state == WRITE) || (r_state == UNCACHED);
  assign w_issue      = w_mem_state && !mem_req && !r_wait;
  assign w_mem_accept = mem_req && mem_addr_ok;
  // A response only counts once its request has been accepted (same cycle or earlier).
  assign w_mem_done   = (w_mem_accept || r_wait) && mem_data_ok;

  always_comb begin
    w_be = 4'b1111;
    case (r_size)
      2'd0:    w_be = 4'b0001 << r_addr[1:0];
      2'd1:    w_be = r_addr[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign w_merged[8*i +: 8] = w_be[i] ? r_wdata[8*i +: 8] : w_word[8*i +: 8];
  end

  always_comb begin
    w_state_nxt      = r_state;
    cpu_data_addr_ok = 1'b0;
    cpu_data_data_ok = 1'b0;
    w_rd_fire        = 1'b0;
    w_rd_word        = w_word;
    case (r_state)
      IDLE: begin
        cpu_data_addr_ok = cpu_data_req & resetn;
        if (cpu_data_req && resetn) w_state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (w_uncached)  w_state_nxt = UNCACHED;
        else if (r_wr)   w_state_nxt = WRITE;
        else if (w_hit) begin
          cpu_data_data_ok = 1'b1;
          w_rd_fire        = 1'b1;
          w_state_nxt      = IDLE;
        end else         w_state_nxt = REFILL;
      end
      REFILL: if (w_mem_done && r_cnt == 2'd3) w_state_nxt = RESP;
      RESP: begin
        cpu_data_data_ok = 1'b1;
        w_rd_fire        = 1'b1;
        w_state_nxt      = IDLE;
      end
      WRITE: if (w_mem_done) begin
        cpu_data_data_ok = 1'b1;
        w_state_nxt      = IDLE;
      end
      UNCACHED: if (w_mem_done) begin
        cpu_data_data_ok = 1'b1;
        w_rd_fire        = !r_wr;
        w_rd_word        = mem_rdata;
        w_state_nxt      = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Registered read data is bypassed during the data_ok cycle so it is valid with the pulse.
  assign cpu_data_rdata = w_rd_fire ? w_rd_word : r_rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_valid   <= '0;
      r_rdata   <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wr      <= 1'b0;
      r_size    <= 2'd0;
      r_cnt     <= 2'd0;
      r_wait    <= 1'b0;
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_size  <= 2'd0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_rd_fire) r_rdata <= w_rd_word;
      if (cpu_data_addr_ok) begin
        r_addr  <= cpu_data_addr;
        r_wr    <= cpu_data_wr;
        r_size  <= cpu_data_size;
        r_wdata <= cpu_data_wdata;
        r_cnt   <= 2'd0;
        r_wait  <= 1'b0;
      end
      if (w_issue) begin
        mem_req   <= 1'b1;
        mem_addr  <= (r_state == REFILL) ? {r_addr[31:4], r_cnt, 2'b00} : r_addr;
        mem_size  <= (r_state == REFILL) ? 2'd2 : r_size;
        mem_wr    <= (r_state == WRITE) || ((r_state == UNCACHED) && r_wr);
        mem_wdata <= r_wdata;
      end
      if (w_mem_accept) begin
        mem_req <= 1'b0;
        if (!mem_data_ok) r_wait <= 1'b1;
      end
      if (r_wait && mem_data_ok) r_wait <= 1'b0;
      // Next refill beat goes out immediately so mem_req rises the cycle after data_ok.
      if (w_mem_done && r_state == REFILL) begin
        r_cnt <= r_cnt + 2'd1;
        if (r_cnt != 2'd3) begin
          mem_req  <= 1'b1;
          mem_addr <= {r_addr[31:4], r_cnt + 2'd1, 2'b00};
        end else begin
          r_valid[w_index] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == LOOKUP && !w_uncached && r_wr && w_hit)
      r_data[{w_index, r_addr[3:2]}] <= w_merged;
    if (r_state == REFILL && w_mem_done) begin
      r_data[{w_index, r_cnt}] <= mem_rdata;
      if (r_cnt == 2'd3) r_tag[w_index] <= w_tag;
    end
  end

`ifdef D_CACHE_STAT_EN
  logic [31:0] r_stat_hit, r_stat_miss;
  logic        w_lookup_cached;

  assign w_lookup_cached = (r_state == LOOKUP) && !w_uncached;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stat_hit  <= '0;
      r_stat_miss <= '0;
    end else if (w_lookup_cached) begin
      if (w_hit) r_stat_hit  <= r_stat_hit + 32'd1;
      else       r_stat_miss <= r_stat_miss + 32'd1;
    end
  end

  assign stat_hit  = r_stat_hit;
  assign stat_miss = r_stat_miss;
`else
  assign stat_hit  = '0;
  assign stat_miss = '0;
`endif

endmodule

`default_nettype wire
